// File: rtl/hex_pkg.sv
// Shared constants and state encoding for the hex line streamer.
// Lines are "<ch>:<8 hex digits>\r\n", LINE_LEN bytes each.
package hex_pkg;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam int         LINE_LEN    = 12;

   typedef enum logic {IDLE, SEND} state_e;
endpackage

// File: rtl/hex_nibble_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_nibble_ascii
   import hex_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);
   always_comb begin
      if (nibble <= 4'd9) ascii = ASCII_ZERO + {4'h0, nibble};
      else                ascii = 8'h37 + {4'h0, nibble};
   end
endmodule

// File: rtl/hex_line_streamer.sv
// Round-robin arbiter that latches one requester's 32-bit value and streams it
// as a 12-byte ASCII line over a valid/ready byte channel.
module hex_line_streamer
   import hex_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_CH-1:0]      req,
   input  logic [32*NUM_CH-1:0]   value,
   output logic [NUM_CH-1:0]      grant,
   output logic [7:0]             tx_data,
   output logic                   tx_valid,
   input  logic                   tx_ready
);
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int IDX_LAST = LINE_LEN - 1;

   state_e              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [CH_W-1:0]     last_q, last_d;
   logic [31:0]         val_q, val_d;
   logic [3:0]          idx_q, idx_d;
   logic [NUM_CH-1:0]   grant_q, grant_d;

   logic                pick_found;
   logic [CH_W-1:0]     pick_ch;
   logic [CH_W-1:0]     cand_ch;
   int                  cand;
   logic [5:0]          shamt;
   logic [3:0]          nibble;
   logic [7:0]          hex_char;
   logic [7:0]          line_byte;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      pick_found = 1'b0;
      pick_ch    = '0;
      cand       = 0;
      cand_ch    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand    = (int'(last_q) + 1 + i) % NUM_CH;
         cand_ch = CH_W'(cand);
         if (!pick_found && req[cand_ch]) begin
            pick_found = 1'b1;
            pick_ch    = cand_ch;
         end
      end
   end

   // Byte indices 2..9 map to nibbles [31:28] down to [3:0].
   assign shamt  = {4'd9 - idx_q, 2'b00};
   assign nibble = 4'(val_q >> shamt);

   hex_nibble_ascii u_nib (
      .nibble (nibble),
      .ascii  (hex_char)
   );

   always_comb begin
      case (idx_q)
         4'd0:    line_byte = ASCII_ZERO + 8'(ch_q);
         4'd1:    line_byte = ASCII_COLON;
         4'd10:   line_byte = ASCII_CR;
         4'd11:   line_byte = ASCII_LF;
         default: line_byte = hex_char;
      endcase
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      last_d  = last_q;
      val_d   = val_q;
      idx_d   = idx_q;
      grant_d = '0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               ch_d             = pick_ch;
               last_d           = pick_ch;
               val_d            = value[{pick_ch, 5'b0} +: 32];
               idx_d            = '0;
               grant_d[pick_ch] = 1'b1;
               state_d          = SEND;
            end
         end
         SEND: begin
            if (tx_ready) begin
               if (idx_q == 4'(IDX_LAST)) begin
                  state_d = IDLE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ch_q    <= '0;
         last_q  <= CH_W'(NUM_CH - 1);
         val_q   <= '0;
         idx_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         last_q  <= last_d;
         val_q   <= val_d;
         idx_q   <= idx_d;
         grant_q <= grant_d;
      end
   end

   assign grant    = grant_q;
   assign tx_valid = (state_q == SEND);
   assign tx_data  = tx_valid ? line_byte : 8'h00;
endmodule

// File: doc/hex_line_streamer.md
# hex_line_streamer

Round-robin scheduler that shares one byte-wide ASCII output channel, typically the debug UART transmitter, among NUM_CH requesters. Each requester presents a 32-bit value. The block grants one requester at a time, latches its value, and streams a fixed 12-byte text line: channel digit, colon, 8 uppercase hex digits (MSB nibble first), CR, LF. It sits between the status/telemetry registers and the UART TX byte interface.

## Interface
- NUM_CH, 4, number of requesters; legal range 1..10 so the channel id is a single ASCII digit
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- req  in  NUM_CH  level request per channel; requester holds req and its value until it sees grant
- value  in  32*NUM_CH  channel k value on bits [32k+31:32k]
- grant  out  NUM_CH  one-hot, one-cycle pulse marking the edge at which the value was captured
- tx_data  out  8  ASCII byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte; transfer occurs when tx_valid & tx_ready

## Operation
- States: IDLE, SEND.
- In IDLE with req != 0, one clock edge does all of the following: latch value and channel index of the winner, set grant to the winner's one-hot, load byte index 0, set tx_valid to 1, and move to SEND.
- In IDLE with req == 0: stay in IDLE; tx_valid = 0; grant = 0.
- Arbitration is round-robin. The search starts at (last_granted + 1) mod NUM_CH. last_granted resets to NUM_CH-1, so channel 0 has first priority after reset.
- Line bytes, by index:
  - 0: 8'h30 + channel
  - 1: 8'h3A
  - 2..9: hex digits for nibbles [31:28] down to [3:0]
  - 10: 8'h0D
  - 11: 8'h0A
- Nibble n converts to 8'h30+n for n ≤ 9 and 8'h37+n for n ≥ 10 (uppercase A–F). Arithmetic is 8-bit; no overflow is possible.
- In SEND, each transfer increments the byte index. On the transfer of index 11, tx_valid drops to 0 and the state returns to IDLE.
- req is sampled only in IDLE. If req is still high after its line completes, it counts as a new request and competes normally.
- Changes to req or value during SEND have no effect on the line in progress.
- Synchronous reset at any time, including mid-line, abandons the current line with no completion. Next cycle: state IDLE, tx_valid 0, grant 0, tx_data 8'h00, byte index 0, last_granted NUM_CH-1.

## Timing
- Reset values: grant 0, tx_valid 0, tx_data 8'h00.
- Latency: req high in IDLE at edge E means grant and tx_valid (byte 0) are both high in the cycle after E.
- Handshake: while tx_valid=1 and tx_ready=0, tx_data and the byte index hold stable. tx_valid never drops before the transfer completes.
- tx_ready is don't-care while tx_valid=0.
- Throughput with tx_ready stuck at 1: 12 transfer cycles plus 1 IDLE cycle, so one line every 13 cycles. There is a mandatory one-cycle gap between lines.
- grant is high for exactly one cycle per line, and never during reset.

## Structure
- Shared package hex_pkg holds:
  - constants ASCII_ZERO (8'h30), ASCII_COLON (8'h3A), ASCII_CR (8'h0D), ASCII_LF (8'h0A), LINE_LEN (12)
  - the state enum {IDLE, SEND}
- One combinational sub-module, hex_nibble_ascii: 4-bit nibble in, 8-bit uppercase ASCII out. The byte mux drives it with the nibble selected by the byte index.
- The round-robin picker is an inline function or always block; it needs no separate module.

## Test plan
- **Single channel, value 32'hDEADBEEF:** ch2 requests, tx_ready=1.
  - Required bytes: 32 3A 44 45 41 44 42 45 45 46 0D 0A.
  - grant=4'b0100 for one cycle, in the same cycle as the first tx_valid.
- **Backpressure:** ch0, value 32'h0123456A, with tx_ready toggled pseudo-randomly.
  - Required bytes: 30 3A 30 31 32 33 34 35 36 41 0D 0A.
  - tx_data is stable during every stall and no byte is lost or duplicated.
- **Round-robin:** req=4'b1111 held, each requester drops req on its grant and re-raises it 2 cycles later.
  - Grant order is 0,1,2,3,0,1.
  - With tx_ready=1, consecutive lines start 13 cycles apart.
- **Value change mid-line:** ch1 value changes from 32'h11111111 to 32'hFFFFFFFF during SEND.
  - The emitted line is still all '1' digits.
- **Reset mid-line:** reset_n low during byte index 5.
  - Next cycle tx_valid=0, grant=0.
  - After release with req=4'b0011, channel 0 is granted first and a full 12-byte line follows.
- **NUM_CH=10 build:** ch9 requests with value 32'h00000000.
  - Required bytes: 39 3A followed by eight 30, then 0D 0A.
